mips_mem_if: RTL and testbench
==============================

// Module: mips_mem_if
// PURPOSE
//  Memory port unit between the multi-cycle MIPS core (mem_read/mem_write/inst_data_adr/
//  mem_data_in/mem_out) and a variable-latency memory. Latches each core access, runs a
//  req/ack handshake with wait-state counting and timeout, and returns data plus a
//  core_stall/core_done pair. The controller then holds its FSM until the access completes.
// PARAMETERS
//  DATA_W   32   data bus width
//  ADDR_W   32   address bus width
//  MIN_LAT  0    minimum wait cycles in WAIT before mem_ack is honoured
//  TIMEOUT  15   WAIT cycles without ack before abort (must be > MIN_LAT)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       synchronous, active-high reset
//  core_rd      in   1       read request from controller (level, sampled in IDLE)
//  core_wr      in   1       write request from controller
//  core_adr     in   ADDR_W  byte address from datapath
//  core_wdata   in   DATA_W  write data from datapath
//  core_rdata   out  DATA_W  registered read data to datapath
//  core_stall   out  1       core must hold state
//  core_done    out  1       one-cycle pulse: access finished
//  mem_req      out  1       memory request, held until ack or abort
//  mem_we       out  1       1 = write, 0 = read (valid while mem_req)
//  mem_adr      out  ADDR_W  latched address
//  mem_wdata    out  DATA_W  latched write data
//  mem_rdata    in   DATA_W  memory read data, valid with mem_ack
//  mem_ack      in   1       memory completion strobe
//  err          out  1       one-cycle pulse: timeout (or misalign, see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE, wait counter=0; core_rdata=0, mem_req=0, mem_we=0, mem_adr=0,
//    mem_wdata=0, core_done=0, err=0. Reset mid-access aborts it: no done, no err.
//  - FSM IDLE -> WAIT -> DONE -> IDLE; abort path WAIT -> IDLE.
//  - IDLE: if core_rd|core_wr, latch core_adr/core_wdata, mem_we<=core_wr, mem_req<=1,
//    counter<=0, go WAIT. If both rd and wr are high, the write is performed.
//  - WAIT: counter increments every cycle, saturating at TIMEOUT. Completion when
//    mem_ack=1 and counter>=MIN_LAT: read captures mem_rdata into core_rdata;
//    mem_req<=0; go DONE. An ack with counter<MIN_LAT is ignored.
//    If counter==TIMEOUT and no valid ack: mem_req<=0, err pulses 1 cycle, go IDLE,
//    core_rdata is left unchanged, and no core_done is issued.
//  - DONE: core_done=1 for exactly one cycle; go IDLE. Requests seen in DONE are not
//    accepted; they are sampled in the following IDLE cycle.
//  - core_stall = (IDLE & (core_rd|core_wr)) | WAIT (combinational). Low in DONE.
//  - Latency (MIN_LAT=0, ack in the first WAIT cycle): request at cycle 0 -> mem_req
//    high cycles 1..1 -> core_done at cycle 2. Each extra wait cycle adds 1.
//  - A write never changes core_rdata. mem_adr/mem_wdata hold their value after completion.
//  - Counter width is $clog2(TIMEOUT+1); no wrap.
// CONFIGURATION
//  MIPS_MEM_IF_ALIGN_CHK_EN defined: in IDLE, a request whose core_adr[1:0]!=0 is
//   rejected. mem_req stays 0, err pulses the next cycle, core_done is not issued, and
//   core_stall is asserted only in the request cycle.
//  Undefined: there is no alignment check, the address passes through unmodified, and
//   err means timeout only.
// TESTING
//  1 rst=1 for 2 cycles with core_rd=1 -> every output is 0 and mem_req never rises.
//  2 read adr=0x40, MIN_LAT=0, memory acks at once with 0xDEADBEEF -> core_done at
//    cycle 2, core_rdata=0xDEADBEEF, stall high in cycles 0-1.
//  3 write adr=0x44, data=0x12345678, MIN_LAT=2, ack held high -> mem_we=1, mem_req
//    high for 3 cycles, core_rdata unchanged, core_done at cycle 4.
//  4 read, ack never arrives, TIMEOUT=15 -> err pulse 16 cycles after mem_req rises,
//    no core_done, FSM returns to IDLE and the next read completes normally.
//  5 core_rd=core_wr=1 together -> write performed; back-to-back request held through
//    DONE -> second access starts in the following IDLE cycle.
//  6 with MIPS_MEM_IF_ALIGN_CHK_EN defined, read adr=0x42 -> err=1, mem_req=0, no done;
//    without the macro -> normal access to 0x42.

Source files
------------

// File: rtl/mips_mem_if.sv
// mips_mem_if: memory port unit between the multi-cycle MIPS core and a variable-latency memory.
// Latches one core access, runs a req/ack handshake with wait-state counting and timeout,
// and returns read data together with core_stall/core_done.
// Parameters: DATA_W, ADDR_W bus widths; MIN_LAT wait cycles before an ack is honoured;
//   TIMEOUT wait cycles without a valid ack before the access is aborted (> MIN_LAT).
// Ports:
//   clk, rst                         clock and synchronous active-high reset
//   core_rd, core_wr                 access request from the controller (sampled in IDLE)
//   core_adr, core_wdata             byte address and write data from the datapath
//   core_rdata                       registered read data to the datapath
//   core_stall, core_done            hold request to the core / one-cycle completion pulse
//   mem_req, mem_we                  memory request and direction (1 = write)
//   mem_adr, mem_wdata               latched address and write data
//   mem_rdata, mem_ack               memory read data and completion strobe
//   err                              one-cycle pulse on timeout or rejected misaligned access
// Optional feature: define MIPS_MEM_IF_ALIGN_CHK_EN to reject requests with core_adr[1:0] != 0.
module mips_mem_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MIN_LAT = 0,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_rd,
    input  logic              core_wr,
    input  logic [ADDR_W-1:0] core_adr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    output logic              core_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic req_any;
    logic misalign;
    logic lat_ok;
    assign req_any = core_rd | core_wr;
`ifdef MIPS_MEM_IF_ALIGN_CHK_EN
    assign misalign = core_adr[1:0] != 2'b00;
`else
    assign misalign = 1'b0;
`endif
    // With no minimum latency every ack is valid; avoids an always-true compare.
    if (MIN_LAT == 0) begin : g_nolat
        assign lat_ok = 1'b1;
    end else begin : g_lat
        assign lat_ok = cnt >= CW'(MIN_LAT);
    end
    // Gated by rst so every output reads 0 while reset is held with a pending request.
    assign core_stall = !rst && ((state == IDLE && req_any) || state == WAIT);
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            core_rdata <= '0;
            core_done  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_adr    <= '0;
            mem_wdata  <= '0;
            err        <= 1'b0;
        end else begin
            core_done <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any && misalign) begin
                        err <= 1'b1;
                    end else if (req_any) begin
                        mem_adr   <= core_adr;
                        mem_wdata <= core_wdata;
                        mem_we    <= core_wr;
                        mem_req   <= 1'b1;
                        cnt       <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != TO_C) cnt <= cnt + 1'b1;
                    if (mem_ack && lat_ok) begin
                        if (!mem_we) core_rdata <= mem_rdata;
                        mem_req   <= 1'b0;
                        core_done <= 1'b1;
                        state     <= DONE;
                    end else if (cnt == TO_C) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mem_if.sv
// tb_mips_mem_if: randomized self-checking bench for mips_mem_if with MIN_LAT=0 and MIN_LAT=2 instances.
module tb_mips_mem_if;
    localparam int TO = 15;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic        core_rd [2];
    logic        core_wr [2];
    logic        mem_ack [2];
    logic [31:0] core_adr [2];
    logic [31:0] core_wdata [2];
    logic [31:0] mem_rdata [2];
    logic [31:0] core_rdata [2];
    logic [31:0] mem_adr [2];
    logic [31:0] mem_wdata [2];
    logic        core_stall [2];
    logic        core_done [2];
    logic        mem_req [2];
    logic        mem_we [2];
    logic        err [2];
    logic [31:0] model_rdata [2];
    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mips_mem_if #(.DATA_W(32), .ADDR_W(32), .MIN_LAT(g * 2), .TIMEOUT(TO)) u (
            .clk(clk), .rst(rst),
            .core_rd(core_rd[g]), .core_wr(core_wr[g]),
            .core_adr(core_adr[g]), .core_wdata(core_wdata[g]),
            .core_rdata(core_rdata[g]), .core_stall(core_stall[g]), .core_done(core_done[g]),
            .mem_req(mem_req[g]), .mem_we(mem_we[g]), .mem_adr(mem_adr[g]), .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g]), .mem_ack(mem_ack[g]), .err(err[g])
        );
    end

    // Drives one access into both instances (cycle 0 = request cycle) and compares each
    // instance against the transaction-level expectation derived from the ack pattern:
    // completion happens at the first WAIT index j in [MIN_LAT, TIMEOUT] where ack is high.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] adr,
                              input logic [31:0] wd, input logic [31:0] rdv,
                              input logic [19:0] ackpat, input string name);
        int k [2];
        int done_n [2], done_c [2], err_n [2], err_c [2], req_n [2], stall_n [2];
        int e_done_n, e_done_c, e_err_c, e_req, e_stall;
        bit we_bad [2];
        bit rej = 1'b0;
`ifdef MIPS_MEM_IF_ALIGN_CHK_EN
        rej = adr[1:0] != 2'b00;
`endif
        for (int d = 0; d < 2; d++) begin
            k[d] = -1;
            for (int j = d * 2; j <= TO; j++) if (ackpat[j]) begin k[d] = j; break; end
            done_n[d] = 0; done_c[d] = -1; err_n[d] = 0; err_c[d] = -1;
            req_n[d] = 0; stall_n[d] = 0; we_bad[d] = 1'b0;
            core_rd[d] = rd; core_wr[d] = wr; core_adr[d] = adr; core_wdata[d] = wd;
            mem_rdata[d] = rdv;
        end
        for (int c = 0; c < 20; c++) begin
            for (int d = 0; d < 2; d++) mem_ack[d] = (c >= 1) ? ackpat[c-1] : 1'b0;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (core_done[d]) begin done_n[d]++; if (done_c[d] < 0) done_c[d] = c; end
                if (err[d]) begin err_n[d]++; if (err_c[d] < 0) err_c[d] = c; end
                if (mem_req[d]) begin
                    req_n[d]++;
                    if (mem_we[d] !== wr || mem_adr[d] !== adr) we_bad[d] = 1'b1;
                end
                if (core_stall[d]) stall_n[d]++;
            end
            @(posedge clk); #1;
            if (c == 0) for (int d = 0; d < 2; d++) begin core_rd[d] = 1'b0; core_wr[d] = 1'b0; end
        end
        for (int d = 0; d < 2; d++) begin
            mem_ack[d] = 1'b0;
            if (rej) begin
                e_done_n = 0; e_done_c = -1; e_err_c = 1; e_req = 0; e_stall = 1;
            end else if (k[d] >= 0) begin
                e_done_n = 1; e_done_c = k[d] + 2; e_err_c = -1; e_req = k[d] + 1; e_stall = k[d] + 2;
                if (!wr) model_rdata[d] = rdv;
            end else begin
                e_done_n = 0; e_done_c = -1; e_err_c = TO + 2; e_req = TO + 1; e_stall = TO + 2;
            end
            checks++;
            if (done_n[d] !== e_done_n || done_c[d] !== e_done_c) begin
                errors++;
                $display("FAIL %s dut%0d done: count=%0d cycle=%0d expected count=%0d cycle=%0d",
                         name, d, done_n[d], done_c[d], e_done_n, e_done_c);
            end
            checks++;
            if (err_n[d] !== (e_err_c < 0 ? 0 : 1) || err_c[d] !== e_err_c) begin
                errors++;
                $display("FAIL %s dut%0d err: count=%0d cycle=%0d expected cycle=%0d",
                         name, d, err_n[d], err_c[d], e_err_c);
            end
            checks++;
            if (req_n[d] !== e_req || we_bad[d]) begin
                errors++;
                $display("FAIL %s dut%0d mem_req: cycles=%0d bad_we_adr=%0d expected cycles=%0d",
                         name, d, req_n[d], we_bad[d], e_req);
            end
            checks++;
            if (stall_n[d] !== e_stall) begin
                errors++;
                $display("FAIL %s dut%0d stall: cycles=%0d expected %0d", name, d, stall_n[d], e_stall);
            end
            checks++;
            if (core_rdata[d] !== model_rdata[d]) begin
                errors++;
                $display("FAIL %s dut%0d core_rdata: got %h expected %h", name, d, core_rdata[d], model_rdata[d]);
            end
            if (!rej) begin
                checks++;
                if (mem_adr[d] !== adr || mem_wdata[d] !== wd) begin
                    errors++;
                    $display("FAIL %s dut%0d latched: adr=%h wdata=%h expected adr=%h wdata=%h",
                             name, d, mem_adr[d], mem_wdata[d], adr, wd);
                end
            end
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            core_rd[d] = 1'b1; core_wr[d] = 1'b0; core_adr[d] = 32'h40; core_wdata[d] = 32'h0;
            mem_rdata[d] = 32'h0; mem_ack[d] = 1'b0; model_rdata[d] = 32'h0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (core_rdata[d] !== 32'h0 || mem_adr[d] !== 32'h0 || mem_wdata[d] !== 32'h0 ||
                    core_stall[d] !== 1'b0 || core_done[d] !== 1'b0 || mem_req[d] !== 1'b0 ||
                    mem_we[d] !== 1'b0 || err[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset dut%0d: rdata=%h adr=%h wdata=%h stall=%b done=%b req=%b we=%b err=%b expected all 0",
                             d, core_rdata[d], mem_adr[d], mem_wdata[d], core_stall[d], core_done[d],
                             mem_req[d], mem_we[d], err[d]);
                end
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        for (int d = 0; d < 2; d++) core_rd[d] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_access(1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 20'hFFFFF, "read_ack_now");
        run_access(1'b0, 1'b1, 32'h44, 32'h12345678, 32'hA5A5A5A5, 20'hFFFFF, "write_held_ack");
        run_access(1'b1, 1'b0, 32'h48, 32'h0, 32'h0BADF00D, 20'h0, "timeout");
        run_access(1'b1, 1'b0, 32'h4C, 32'h0, 32'hCAFEF00D, 20'h00008, "read_after_timeout");
        run_access(1'b1, 1'b0, 32'h50, 32'h0, 32'h11112222, 20'h00001, "early_ack_ignored");
        run_access(1'b1, 1'b1, 32'h54, 32'h77778888, 32'h99990000, 20'hFFFFF, "rd_wr_both");
        run_access(1'b1, 1'b0, 32'h42, 32'h0, 32'h13572468, 20'hFFFFF, "misaligned");
    endtask

    task automatic test_random();
        logic rd, wr;
        logic [19:0] pat;
        int r;
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 2);
            rd = (r != 1); wr = (r != 0);
            case ($urandom_range(0, 2))
                0: pat = 20'hFFFFF << $urandom_range(0, 17);
                1: pat = 20'($urandom);
                default: pat = 20'h0;
            endcase
            run_access(rd, wr, $urandom & 32'hFFFFFFFC, $urandom, $urandom, pat, "random");
        end
    endtask

    // Request held through DONE on the MIN_LAT=0 instance: second access begins in the next IDLE cycle.
    task automatic test_back_to_back();
        logic [5:0] e_req, e_done, e_stall;
        logic [31:0] wd;
        e_req = 6'b010010; e_done = 6'b100100; e_stall = 6'b011011;
        wd = $urandom;
        core_rd[0] = 1'b1; core_wr[0] = 1'b1; core_adr[0] = 32'h80; core_wdata[0] = wd;
        mem_ack[0] = 1'b1; mem_rdata[0] = 32'hFFFF0000;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (mem_req[0] !== e_req[c] || core_done[0] !== e_done[c] || core_stall[0] !== e_stall[c] ||
                (mem_req[0] && mem_we[0] !== 1'b1) || mem_req[1] !== 1'b0) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: req=%b done=%b stall=%b we=%b req1=%b expected req=%b done=%b stall=%b we=1 req1=0",
                         c, mem_req[0], core_done[0], core_stall[0], mem_we[0], mem_req[1],
                         e_req[c], e_done[c], e_stall[c]);
            end
            @(posedge clk); #1;
        end
        core_rd[0] = 1'b0; core_wr[0] = 1'b0; mem_ack[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (core_rdata[0] !== model_rdata[0] || mem_wdata[0] !== wd || mem_adr[0] !== 32'h80) begin
            errors++;
            $display("FAIL back_to_back final: rdata=%h wdata=%h adr=%h expected rdata=%h wdata=%h adr=00000080",
                     core_rdata[0], mem_wdata[0], mem_adr[0], model_rdata[0], wd);
        end
    endtask

    task automatic test_reset_mid_access();
        int bad;
        for (int d = 0; d < 2; d++) begin
            core_rd[d] = 1'b1; core_wr[d] = 1'b0; core_adr[d] = 32'h100; mem_ack[d] = 1'b0;
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) core_rd[d] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) model_rdata[d] = 32'h0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            for (int d = 0; d < 2; d++) mem_ack[d] = 1'b1;
            @(negedge clk);
            for (int d = 0; d < 2; d++) if (core_done[d] || err[d] || mem_req[d] || core_stall[d]) bad++;
            @(posedge clk); #1;
        end
        for (int d = 0; d < 2; d++) mem_ack[d] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (bad !== 0 || core_rdata[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset_mid_access dut%0d: activity=%0d rdata=%h expected activity=0 rdata=0",
                         d, bad, core_rdata[d]);
            end
        end
        run_access(1'b1, 1'b0, 32'h104, 32'h0, 32'h2468ACE0, 20'h00010, "read_after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
